sram_activation_dp: RTL and testbench
=====================================

# sram_activation_dp

Parametrised true-dual-port activation buffer for the DNN accelerator, replacing the fixed 2048×8×4 bank arrangement with one configurable array of `DATA_W`-bit words and per-byte write enables on both ports. It adds the following over a bare macro wrapper:
- explicit read-request/valid signalling;
- an optional output pipeline register;
- deterministic same-address collision rules;
- out-of-range address protection;
- a hardware clear sequencer that zeroes the whole array between layers.

It sits between the DMA/bus-side write port and the PE-array-side read port.

## Interface
- `DATA_W`, 32, word width; must be a multiple of 8; `NB = DATA_W/8` byte lanes
- `DEPTH`, 2048, number of words
- `ADDR_W`, 16, port address width; only addresses `< DEPTH` are valid
- `OUT_REG`, 0, 1 adds one output pipeline stage to both read paths
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `init_req`  in  1  start clear sweep (sampled only when idle)
- `init_busy`  out  1  clear sweep in progress
- `init_done`  out  1  one-cycle pulse at end of sweep
- `en0` / `en1`  in  1  port request strobe
- `wea0` / `wea1`  in  NB  byte write enables; all zero means read
- `addr0` / `addr1`  in  ADDR_W  word address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `rdata0` / `rdata1`  out  DATA_W  read data
- `rvalid0` / `rvalid1`  out  1  `rdata` valid this cycle
- `addr_err0` / `addr_err1`  out  1  one-cycle pulse: the request had `addr >= DEPTH`

## Operation
- **Request decoding.** A request is `en=1`. It is a write if `wea != 0`, otherwise a read.
- **Writes.** Only byte lanes with `wea[b]=1` are updated. Writes produce no `rvalid`.
- **Reads.** A read returns the stored word and pulses `rvalid` at the configured latency. `rdata` holds its last value when `rvalid=0`.
- **Out-of-range address (`addr >= DEPTH`).**
  - A write is dropped.
  - A read returns all-zero data with `rvalid=1`.
  - `addr_err` pulses with the same latency as `rvalid`.
- **Write/write collision (same address, same cycle).** Per byte lane:
  - enabled on both ports: port 0 data wins;
  - enabled on one port only: that port's data is written.
- **Read/write collision (same address, same cycle).** Read-first: the read returns the pre-write contents. The write commits.
- **Clear FSM, IDLE → CLEAR.** On `init_req=1`, move to CLEAR and load the sweep counter with 0.
- **Clear FSM, CLEAR.**
  - Write all-zero to address `cnt`, then `cnt++`, one address per cycle.
  - Port requests are ignored: no writes, no `rvalid`, no `addr_err`.
  - `init_req` is ignored.
- **Clear FSM, CLEAR → IDLE.** After writing address `DEPTH-1`, return to IDLE and pulse `init_done` for one cycle.
- **Reset.**
  - FSM goes to IDLE; counter is cleared.
  - `init_busy`, `init_done`, `rvalid*` and `addr_err*` are 0; `rdata*` is 0, including pipeline registers.
  - Array contents are not modified by reset.
  - Reset mid-sweep aborts the sweep: addresses already swept stay zero, the rest keep old data, and no `init_done` is issued.
- **Width rules.** The internal address is `clog2(DEPTH)` bits. The range check uses the full `ADDR_W` input, so no silent aliasing occurs.

## Timing
- **Read latency.** For a request sampled at edge N, `rdata`/`rvalid` are valid after edge N+1 when `OUT_REG=0`, and after edge N+2 when `OUT_REG=1`.
- **Back-to-back reads.** Full throughput: one result per cycle per port, in order.
- **Write visibility.** A write at edge N is visible to a read sampled at edge N+1 or later.
- **Start of sweep.**
  - `init_req` is sampled at edge K.
  - A port request at the same edge K is still honoured.
  - `init_busy=1` for DEPTH cycles, following edges K+1 through K+DEPTH.
- **End of sweep.**
  - `init_done=1` for exactly one cycle after edge K+DEPTH+1, with `init_busy=0`.
  - Port requests are accepted again from edge K+DEPTH+1.
- **Reads in flight at sweep start.** Reads issued before the sweep complete normally through the pipeline.
- **Reset during a pending read.** `rst` asserted while a read is pending cancels it; `rvalid` stays 0.

## Test plan
- **Write then read, both ports.** Port 0 writes `0xDEADBEEF` to addr 5 with `wea=0xF`. Next cycle port 1 reads addr 5. Required: `rdata1=0xDEADBEEF` and `rvalid1=1` one cycle later (two with `OUT_REG=1`).
- **Byte-lane write.** Addr 7 holds `0x11223344`. Port 1 writes `0xAABBCCDD` with `wea=0b0101`. Required: a read returns `0x11BB33DD`.
- **Write/write collision.** Same cycle, addr 9. Port 0 writes `0x000000FF` with `wea=0x1`; port 1 writes `0x12345678` with `wea=0x3`. Required: a read returns `0x000056FF`.
- **Read/write collision.** Addr 3 holds `0xCAFE0000`. In the same cycle port 0 reads addr 3 and port 1 writes `0x0000BEEF` to addr 3. Required: `rdata0=0xCAFE0000`, and a later read returns `0x0000BEEF`.
- **Full sweep with `DEPTH=16`.**
  - Stimulus: fill the array, pulse `init_req`, and keep issuing port requests during the sweep.
  - Required: `init_busy` high for exactly 16 cycles, no `rvalid` during the sweep, `init_done` for one cycle, then all 16 addresses read 0.
- **Sweep abort, out-of-range and reset.**
  - Stimulus: assert `rst` at `cnt=8` of the sweep.
  - Required: addresses 0–7 read 0, addresses 8–15 keep old data, no `init_done`.
  - Stimulus: read addr `DEPTH+2`. Required: `rdata=0`, `rvalid=1`, `addr_err=1`.
  - Required throughout: all outputs are 0 immediately after reset.

Source files
------------

// File: rtl/sram_activation_dp.sv
// True-dual-port activation buffer with byte enables, read-first collisions, range checking,
// an optional output stage and a hardware sweep that zeroes the whole array.
module sram_activation_dp #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2048,
    parameter int ADDR_W  = 16,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic                  en0,
    input  logic                  en1,
    input  logic [DATA_W/8-1:0]   wea0,
    input  logic [DATA_W/8-1:0]   wea1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  addr_err0,
    output logic                  addr_err1
);
    localparam int NB = DATA_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          busy_reg, last_reg, done_reg;
    logic          clearing, last_write;

    assign clearing   = (state_reg == CLEAR);
    assign last_write = clearing && (cnt_reg == AW'(DEPTH - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (init_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (last_write) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status lags the sweep by one cycle so init_done never overlaps init_busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= clearing;
            last_reg  <= last_write;
            done_reg  <= last_reg;
        end
    end

    assign init_busy = busy_reg;
    assign init_done = done_reg;

    logic [1:0]             en_v, req, wr, rd, oob;
    logic [1:0][NB-1:0]     wea_v;
    logic [1:0][ADDR_W-1:0] addr_v;
    logic [1:0][DATA_W-1:0] wdata_v;
    logic [1:0][AW-1:0]     idx;

    assign en_v    = {en1, en0};
    assign wea_v   = {wea1, wea0};
    assign addr_v  = {addr1, addr0};
    assign wdata_v = {wdata1, wdata0};

    genvar gi, gj;
    // Range check uses the full input width so high address bits never alias into the array.
    for (gj = 0; gj < 2; gj++) begin : g_decode
        assign req[gj] = en_v[gj] & ~clearing;
        assign oob[gj] = ({1'b0, addr_v[gj]} >= DEPTH_LIM);
        assign wr[gj]  = req[gj] & (|wea_v[gj]) & ~oob[gj];
        assign rd[gj]  = req[gj] & ~(|wea_v[gj]);
        assign idx[gj] = addr_v[gj][AW-1:0];
    end

    logic [DATA_W-1:0] q0_word, q1_word;

    // Port 0 is written last so it wins any lane both ports enable at the same address.
    for (gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q0_reg, q1_reg;

        always_ff @(posedge clk) begin
            if (!rst) begin
                if (clearing) begin
                    mem[cnt_reg] <= 8'h00;
                end else begin
                    if (wr[1] && wea_v[1][gi]) mem[idx[1]] <= wdata_v[1][gi*8 +: 8];
                    if (wr[0] && wea_v[0][gi]) mem[idx[0]] <= wdata_v[0][gi*8 +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q0_reg <= 8'h00;
                q1_reg <= 8'h00;
            end else begin
                if (rd[0]) q0_reg <= oob[0] ? 8'h00 : mem[idx[0]];
                if (rd[1]) q1_reg <= oob[1] ? 8'h00 : mem[idx[1]];
            end
        end

        assign q0_word[gi*8 +: 8] = q0_reg;
        assign q1_word[gi*8 +: 8] = q1_reg;
    end

    logic [1:0] va_reg, ea_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            va_reg <= 2'b00;
            ea_reg <= 2'b00;
        end else begin
            va_reg <= rd;
            ea_reg <= req & oob;
        end
    end

    logic [1:0][DATA_W-1:0] rdata_v;
    logic [1:0]             rvalid_v, err_v;

    for (gj = 0; gj < 2; gj++) begin : g_port
        logic [DATA_W-1:0] q_word;
        logic [DATA_W-1:0] d1_reg;
        logic              v1_reg, e1_reg;

        assign q_word = (gj == 0) ? q0_word : q1_word;

        always_ff @(posedge clk) begin
            if (rst) begin
                d1_reg <= '0;
                v1_reg <= 1'b0;
                e1_reg <= 1'b0;
            end else begin
                v1_reg <= va_reg[gj];
                e1_reg <= ea_reg[gj];
                if (va_reg[gj]) d1_reg <= q_word;
            end
        end

        if (OUT_REG != 0) begin : g_out
            logic [DATA_W-1:0] d2_reg;
            logic              v2_reg, e2_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    d2_reg <= '0;
                    v2_reg <= 1'b0;
                    e2_reg <= 1'b0;
                end else begin
                    v2_reg <= v1_reg;
                    e2_reg <= e1_reg;
                    if (v1_reg) d2_reg <= d1_reg;
                end
            end

            assign rdata_v[gj]  = d2_reg;
            assign rvalid_v[gj] = v2_reg;
            assign err_v[gj]    = e2_reg;
        end else begin : g_direct
            assign rdata_v[gj]  = d1_reg;
            assign rvalid_v[gj] = v1_reg;
            assign err_v[gj]    = e1_reg;
        end
    end

    assign rdata0    = rdata_v[0];
    assign rdata1    = rdata_v[1];
    assign rvalid0   = rvalid_v[0];
    assign rvalid1   = rvalid_v[1];
    assign addr_err0 = err_v[0];
    assign addr_err1 = err_v[1];
endmodule

// File: tb/tb_sram_activation_dp.sv
// Directed bench for sram_activation_dp (DEPTH=16, no output stage): one task per scenario,
// inputs driven on the falling edge and outputs sampled on the falling edge.
module tb_sram_activation_dp;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_req = 1'b0;
    logic          init_busy, init_done;
    logic          en0, en1;
    logic [3:0]    wea0, wea1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic          rvalid0, rvalid1, addr_err0, addr_err1;

    int checks = 0;
    int failures = 0;

    logic [31:0] rq, rq_late;
    logic        rv_early, rv, re, rv_late;

    always #5 clk = ~clk;

    sram_activation_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(0)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
        .en0(en0), .en1(en1), .wea0(wea0), .wea1(wea1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .addr_err0(addr_err0), .addr_err1(addr_err1)
    );

    task automatic idle_ports();
        en0 = 1'b0; en1 = 1'b0; wea0 = 4'h0; wea1 = 4'h0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic drive(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w);
        if (p == 0) begin en0 = 1'b1; addr0 = a; wdata0 = d; wea0 = w; end
        else        begin en1 = 1'b1; addr1 = a; wdata1 = d; wea1 = w; end
    endtask

    task automatic write_p(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w);
        drive(p, a, d, w);
        @(negedge clk);
        idle_ports();
        $display("write p%0d addr=0x%0h data=0x%08h wea=%b", p, a, d, w);
    endtask

    // Issues one read, then captures the valid one cycle early, on time, and one cycle late.
    task automatic read_p(input int p, input logic [AW-1:0] a);
        drive(p, a, 32'h0, 4'h0);
        @(negedge clk);
        idle_ports();
        rv_early = (p == 0) ? rvalid0 : rvalid1;
        @(negedge clk);
        rq = (p == 0) ? rdata0 : rdata1;
        rv = (p == 0) ? rvalid0 : rvalid1;
        re = (p == 0) ? addr_err0 : addr_err1;
        @(negedge clk);
        rv_late = (p == 0) ? rvalid0 : rvalid1;
        rq_late = (p == 0) ? rdata0 : rdata1;
        $display("read  p%0d addr=0x%0h data=0x%08h valid=%b err=%b", p, a, rq, rv, re);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_ports();
        repeat (3) @(negedge clk);
        checks++; if ({rvalid0, rvalid1, addr_err0, addr_err1, init_busy, init_done} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=000000", {rvalid0, rvalid1, addr_err0, addr_err1, init_busy, init_done}); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_write_read();
        write_p(0, 16'd5, 32'hDEADBEEF, 4'hF);
        read_p(1, 16'd5);
        checks++; if (rv_early !== 1'b0) begin failures++; $display("FAIL wr_rd_early_valid got=%b exp=0", rv_early); end
        checks++; if (rq !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_data got=%h exp=deadbeef", rq); end
        checks++; if (rv !== 1'b1 || re !== 1'b0) begin failures++; $display("FAIL wr_rd_valid got=%b%b exp=10", rv, re); end
        checks++; if (rv_late !== 1'b0) begin failures++; $display("FAIL wr_rd_pulse got=%b exp=0", rv_late); end
        checks++; if (rq_late !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_hold got=%h exp=deadbeef", rq_late); end
    endtask

    task automatic test_byte_lane();
        write_p(0, 16'd7, 32'h11223344, 4'hF);
        write_p(1, 16'd7, 32'hAABBCCDD, 4'b0101);
        read_p(0, 16'd7);
        checks++; if (rq !== 32'h11BB33DD) begin failures++; $display("FAIL byte_lane got=%h exp=11bb33dd", rq); end
    endtask

    task automatic test_ww_collision();
        write_p(0, 16'd9, 32'h0, 4'hF);
        drive(0, 16'd9, 32'h000000FF, 4'h1);
        drive(1, 16'd9, 32'h12345678, 4'h3);
        @(negedge clk);
        idle_ports();
        $display("write p0+p1 addr=0x9 collision");
        read_p(1, 16'd9);
        checks++; if (rq !== 32'h000056FF) begin failures++; $display("FAIL ww_collision got=%h exp=000056ff", rq); end
    endtask

    task automatic test_rw_collision();
        write_p(1, 16'd3, 32'hCAFE0000, 4'hF);
        drive(0, 16'd3, 32'h0, 4'h0);
        drive(1, 16'd3, 32'h0000BEEF, 4'hF);
        @(negedge clk);
        idle_ports();
        @(negedge clk);
        $display("read p0 / write p1 addr=0x3 data=0x%08h", rdata0);
        checks++; if (rdata0 !== 32'hCAFE0000 || rvalid0 !== 1'b1) begin
            failures++; $display("FAIL rw_read_first got=%h v=%b exp=cafe0000 v=1", rdata0, rvalid0); end
        read_p(0, 16'd3);
        checks++; if (rq !== 32'h0000BEEF) begin failures++; $display("FAIL rw_commit got=%h exp=0000beef", rq); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) write_p(0, 16'(10 + i), 32'hB0 + i, 4'hF);
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                drive(0, 16'(10 + i), 32'h0, 4'h0);
                drive(1, 16'(13 - i), 32'h0, 4'h0);
            end else begin
                idle_ports();
            end
            @(negedge clk);
            if (i >= 1) begin
                $display("b2b beat %0d p0=0x%08h p1=0x%08h", i - 1, rdata0, rdata1);
                checks++; if (rdata0 !== 32'hB0 + (i - 1) || rvalid0 !== 1'b1) begin
                    failures++; $display("FAIL b2b_p0_beat%0d got=%h v=%b exp=%h v=1", i - 1, rdata0, rvalid0, 32'hB0 + (i - 1)); end
                checks++; if (rdata1 !== 32'hB3 - (i - 1) || rvalid1 !== 1'b1) begin
                    failures++; $display("FAIL b2b_p1_beat%0d got=%h v=%b exp=%h v=1", i - 1, rdata1, rvalid1, 32'hB3 - (i - 1)); end
            end
        end
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            failures++; $display("FAIL b2b_tail got=%b%b exp=00", rvalid0, rvalid1); end
    endtask

    task automatic test_sweep();
        int busy_n = 0, done_n = 0, done_at = -1, busy_first = -1, stray = 0;
        for (int i = 0; i < DEPTH; i++) write_p(i % 2, 16'(i), 32'h100 + i, 4'hF);
        init_req = 1'b1;
        drive(0, 16'd2, 32'h0, 4'h0);
        @(negedge clk);
        init_req = 1'b0;
        idle_ports();
        for (int c = 1; c <= 20; c++) begin
            idle_ports();
            init_req = (c == 5);
            if (c <= 16) begin
                drive(0, (c % 4 == 0) ? 16'd20 : 16'(c % 16), 32'h0, 4'h0);
                drive(1, 16'((c + 14) % 16), 32'hFFFFFFFF, 4'hF);
            end
            @(negedge clk);
            if (init_busy) begin busy_n++; if (busy_first < 0) busy_first = c; end
            if (init_done) begin done_n++; done_at = c; end
            if (c == 1) begin
                checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h102) begin
                    failures++; $display("FAIL sweep_inflight_read got=%h v=%b exp=00000102 v=1", rdata0, rvalid0); end
            end else if (rvalid0 || rvalid1 || addr_err0 || addr_err1) begin
                stray++;
            end
        end
        init_req = 1'b0;
        idle_ports();
        $display("sweep busy=%0d first=%0d done=%0d at=%0d stray=%0d", busy_n, busy_first, done_n, done_at, stray);
        checks++; if (busy_n != 16 || busy_first != 1) begin
            failures++; $display("FAIL sweep_busy got=%0d from %0d exp=16 from 1", busy_n, busy_first); end
        checks++; if (done_n != 1 || done_at != 17) begin
            failures++; $display("FAIL sweep_done got=%0d at %0d exp=1 at 17", done_n, done_at); end
        checks++; if (stray != 0) begin failures++; $display("FAIL sweep_ports_ignored got=%0d exp=0", stray); end
        for (int i = 0; i < DEPTH; i++) begin
            read_p(i % 2, 16'(i));
            checks++; if (rq !== 32'h0 || rv !== 1'b1) begin
                failures++; $display("FAIL sweep_zero_addr%0d got=%h v=%b exp=0 v=1", i, rq, rv); end
        end
    endtask

    task automatic test_abort();
        logic done_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_p(0, 16'(i), 32'h200 + i, 4'hF);
        read_p(1, 16'd15);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("abort reset at cnt=8");
        checks++; if ({init_busy, init_done, rvalid0, rvalid1, addr_err0, addr_err1} !== 6'b0) begin
            failures++; $display("FAIL abort_reset_flags got=%b exp=000000", {init_busy, init_done, rvalid0, rvalid1, addr_err0, addr_err1}); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            failures++; $display("FAIL abort_reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (init_done || init_busy) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", done_seen); end
        for (int i = 0; i < DEPTH; i++) begin
            read_p(0, 16'(i));
            checks++; if (rq !== ((i < 8) ? 32'h0 : 32'h200 + i)) begin
                failures++; $display("FAIL abort_addr%0d got=%h exp=%h", i, rq, (i < 8) ? 32'h0 : 32'h200 + i); end
        end
    endtask

    task automatic test_pending_reset();
        write_p(0, 16'd4, 32'h44444444, 4'hF);
        drive(0, 16'd4, 32'h0, 4'h0);
        @(negedge clk);
        idle_ports();
        rst = 1'b1;
        @(negedge clk);
        $display("reset with read pending rvalid0=%b rdata0=0x%08h", rvalid0, rdata0);
        checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin
            failures++; $display("FAIL pending_cancel got=%h v=%b exp=0 v=0", rdata0, rvalid0); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL pending_after got=%b exp=0", rvalid0); end
    endtask

    task automatic test_out_of_range();
        write_p(0, 16'd0, 32'h55AA55AA, 4'hF);
        read_p(0, 16'(DEPTH + 2));
        checks++; if (rq !== 32'h0 || rv !== 1'b1 || re !== 1'b1) begin
            failures++; $display("FAIL oor_read got=%h v=%b e=%b exp=0 v=1 e=1", rq, rv, re); end
        checks++; if (rv_early !== 1'b0) begin failures++; $display("FAIL oor_early got=%b exp=0", rv_early); end
        drive(1, 16'd16, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        idle_ports();
        @(negedge clk);
        $display("write p1 addr=0x10 out of range err=%b valid=%b", addr_err1, rvalid1);
        checks++; if (addr_err1 !== 1'b1 || rvalid1 !== 1'b0) begin
            failures++; $display("FAIL oor_write_err got=e%b v%b exp=e1 v0", addr_err1, rvalid1); end
        read_p(0, 16'd0);
        checks++; if (rq !== 32'h55AA55AA || re !== 1'b0) begin
            failures++; $display("FAIL oor_no_alias got=%h e=%b exp=55aa55aa e=0", rq, re); end
        read_p(1, 16'h8000);
        checks++; if (re !== 1'b1 || rq !== 32'h0) begin
            failures++; $display("FAIL oor_high_bit got=%h e=%b exp=0 e=1", rq, re); end
    endtask

    initial begin
        idle_ports();
        test_reset();
        test_write_read();
        test_byte_lane();
        test_ww_collision();
        test_rw_collision();
        test_back_to_back();
        test_sweep();
        test_abort();
        test_pending_reset();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
